// File: rtl/qu_common.sv
// Qu core shared types for the reservation station and issue logic.
// Entry index type, issue-port bundle and port state encoding.
package qu_common;

  localparam int QU_RS_DEPTH        = 8;
  localparam int QU_RS_ADDR_WIDTH   = $clog2(QU_RS_DEPTH);
  localparam int QU_NUM_ISSUE_PORTS = 2;

  typedef logic [QU_RS_ADDR_WIDTH-1:0] res_st_addr_t;

  typedef struct packed {
    logic         valid;
    res_st_addr_t addr;
  } issue_port_t;

  typedef enum logic {
    PORT_IDLE  = 1'b0,
    PORT_GRANT = 1'b1
  } port_st_e;

endpackage

// File: rtl/qu_rr_pick.sv
// Masked round-robin find-first over the reservation station.
// Scans start, start+1, ... modulo DEPTH; DEPTH must be a power of two.
module qu_rr_pick #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  input  logic [AW-1:0]    start,
  input  logic [DEPTH-1:0] excl,
  output logic             found,
  output logic [AW-1:0]    idx
);

  logic [DEPTH-1:0] mask;
  logic [AW-1:0]    k;

  assign mask = req & ~excl;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      k = start + AW'(i);
      if (!found && mask[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/qu_issue_sched.sv
// Qu dual-port issue scheduler: round-robin picks from the reservation
// station, grants held under valid/ready, entries freed on acceptance.
module qu_issue_sched
  import qu_common::*;
#(
  parameter int RS_DEPTH      = 8,
  parameter int RS_ADDR_WIDTH = $clog2(RS_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [RS_DEPTH-1:0] entry_valid,
  input  logic [RS_DEPTH-1:0] entry_ready,
  output logic                iss0_valid,
  output res_st_addr_t        iss0_addr,
  input  logic                iss0_ready,
  output logic                iss1_valid,
  output res_st_addr_t        iss1_addr,
  input  logic                iss1_ready,
  output logic [RS_DEPTH-1:0] entry_clr
);

  localparam logic [RS_DEPTH-1:0] ONE = RS_DEPTH'(1);

  port_st_e      st0_q, st1_q;
  res_st_addr_t  a0_q, a1_q;
  res_st_addr_t  rr_ptr;

  logic [RS_DEPTH-1:0] req, held, excl, b_excl;
  logic                need0, need1, g0, g1;
  logic                a_found, b_found;
  res_st_addr_t        a_idx, b_idx, b_start;

  assign iss0_valid = (st0_q == PORT_GRANT);
  assign iss1_valid = (st1_q == PORT_GRANT);
  assign iss0_addr  = a0_q;
  assign iss1_addr  = a1_q;

  assign need0 = ~iss0_valid | iss0_ready;
  assign need1 = ~iss1_valid | iss1_ready;

  always_comb begin
    entry_clr = '0;
    held      = '0;
    if (iss0_valid && iss0_ready && !flush)
      entry_clr = entry_clr | (ONE << a0_q);
    if (iss1_valid && iss1_ready && !flush)
      entry_clr = entry_clr | (ONE << a1_q);
    if (iss0_valid && !iss0_ready)
      held = held | (ONE << a0_q);
    if (iss1_valid && !iss1_ready)
      held = held | (ONE << a1_q);
  end

  // Held and just-accepted entries are both unavailable this cycle.
  assign req  = entry_valid & entry_ready;
  assign excl = held | entry_clr;

  qu_rr_pick #(
    .DEPTH (RS_DEPTH),
    .AW    (RS_ADDR_WIDTH)
  ) u_pick0 (
    .req   (req),
    .start (rr_ptr),
    .excl  (excl),
    .found (a_found),
    .idx   (a_idx)
  );

  // Port 1 continues the scan past port 0's pick when both need one.
  assign b_start = need0 ? res_st_addr_t'(a_idx + 1'b1) : rr_ptr;
  assign b_excl  = excl | ((need0 && a_found) ? (ONE << a_idx) : '0);

  qu_rr_pick #(
    .DEPTH (RS_DEPTH),
    .AW    (RS_ADDR_WIDTH)
  ) u_pick1 (
    .req   (req),
    .start (b_start),
    .excl  (b_excl),
    .found (b_found),
    .idx   (b_idx)
  );

  assign g0 = ~flush & need0 & a_found;
  assign g1 = ~flush & need1 & b_found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st0_q  <= PORT_IDLE;
      st1_q  <= PORT_IDLE;
      a0_q   <= '0;
      a1_q   <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      st0_q <= PORT_IDLE;
      st1_q <= PORT_IDLE;
    end else begin
      if (need0) begin
        st0_q <= g0 ? PORT_GRANT : PORT_IDLE;
        if (g0) a0_q <= a_idx;
      end
      if (need1) begin
        st1_q <= g1 ? PORT_GRANT : PORT_IDLE;
        if (g1) a1_q <= b_idx;
      end
      if (g1)
        rr_ptr <= res_st_addr_t'(b_idx + 1'b1);
      else if (g0)
        rr_ptr <= res_st_addr_t'(a_idx + 1'b1);
    end
  end

endmodule

// File: tb/tb_qu_issue_sched.sv
// Directed bench for qu_issue_sched: reset, single/dual issue,
// wrap-around, backpressure, flush and asynchronous reset.
module tb_qu_issue_sched;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] entry_valid;
  logic [7:0] entry_ready;
  logic       iss0_valid;
  logic [2:0] iss0_addr;
  logic       iss0_ready;
  logic       iss1_valid;
  logic [2:0] iss1_addr;
  logic       iss1_ready;
  logic [7:0] entry_clr;

  int n_cmp = 0;
  int n_err = 0;

  qu_issue_sched dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .iss0_valid  (iss0_valid),
    .iss0_addr   (iss0_addr),
    .iss0_ready  (iss0_ready),
    .iss1_valid  (iss1_valid),
    .iss1_addr   (iss1_addr),
    .iss1_ready  (iss1_ready),
    .entry_clr   (entry_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic set_mask(input logic [7:0] m);
    entry_valid = m;
    entry_ready = m;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    flush      = 1'b0;
    iss0_ready = 1'b0;
    iss1_ready = 1'b0;
    set_mask(8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    flush      = 1'b0;
    iss0_ready = 1'b1;
    iss1_ready = 1'b1;
    set_mask(8'hff);
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_v0: got %b want 0", iss0_valid);
    end
    n_cmp++;
    if (iss1_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_v1: got %b want 0", iss1_valid);
    end
    n_cmp++;
    if (iss0_addr !== 3'd0 || iss1_addr !== 3'd0) begin
      n_err++;
      $display("FAIL reset_addr: got %0d/%0d want 0/0", iss0_addr, iss1_addr);
    end
    n_cmp++;
    if (entry_clr !== 8'h00) begin
      n_err++; $display("FAIL reset_clr: got %b want 0", entry_clr);
    end
    n_cmp++;
    if (dut.rr_ptr !== 3'd0) begin
      n_err++; $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_mask(8'b0000_0100);
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b1 || iss0_addr !== 3'd2 || iss1_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_grant: got v0=%b a0=%0d v1=%b want 1/2/0",
               iss0_valid, iss0_addr, iss1_valid);
    end
    n_cmp++;
    if (dut.rr_ptr !== 3'd3) begin
      n_err++; $display("FAIL single_ptr: got %0d want 3", dut.rr_ptr);
    end
    iss0_ready = 1'b1;
    #1;
    n_cmp++;
    if (entry_clr !== 8'b0000_0100) begin
      n_err++; $display("FAIL single_clr: got %b want 00000100", entry_clr);
    end
    set_mask(8'h00);
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b0 || dut.rr_ptr !== 3'd3) begin
      n_err++;
      $display("FAIL single_idle: got v0=%b ptr=%0d want 0/3",
               iss0_valid, dut.rr_ptr);
    end
    iss0_ready = 1'b0;
  endtask

  task automatic test_dual();
    do_reset();
    set_mask(8'b0110_0010);
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b1 || iss0_addr !== 3'd1 ||
        iss1_valid !== 1'b1 || iss1_addr !== 3'd5) begin
      n_err++;
      $display("FAIL dual_grant: got %b:%0d %b:%0d want 1:1 1:5",
               iss0_valid, iss0_addr, iss1_valid, iss1_addr);
    end
    iss0_ready = 1'b1;
    iss1_ready = 1'b1;
    #1;
    n_cmp++;
    if (entry_clr !== 8'b0010_0010) begin
      n_err++; $display("FAIL dual_clr: got %b want 00100010", entry_clr);
    end
    set_mask(8'b0100_0000);
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b1 || iss0_addr !== 3'd6 || iss1_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dual_next: got v0=%b a0=%0d v1=%b want 1/6/0",
               iss0_valid, iss0_addr, iss1_valid);
    end
    iss0_ready = 1'b0;
    iss1_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    set_mask(8'b0010_0000);
    tick();
    n_cmp++;
    if (iss0_addr !== 3'd5 || dut.rr_ptr !== 3'd6) begin
      n_err++;
      $display("FAIL wrap_setup: got a0=%0d ptr=%0d want 5/6",
               iss0_addr, dut.rr_ptr);
    end
    iss0_ready = 1'b1;
    set_mask(8'b1000_0001);
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b1 || iss0_addr !== 3'd7 ||
        iss1_valid !== 1'b1 || iss1_addr !== 3'd0) begin
      n_err++;
      $display("FAIL wrap_grant: got %b:%0d %b:%0d want 1:7 1:0",
               iss0_valid, iss0_addr, iss1_valid, iss1_addr);
    end
    n_cmp++;
    if (dut.rr_ptr !== 3'd1) begin
      n_err++; $display("FAIL wrap_ptr: got %0d want 1", dut.rr_ptr);
    end
    iss0_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] m;
    logic [7:0] exp;
    do_reset();
    m = 8'b0011_1111;
    set_mask(m);
    iss1_ready = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      exp = 8'd1 << k;
      n_cmp++;
      if (iss0_valid !== 1'b1 || iss0_addr !== 3'd0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v0=%b a0=%0d want 1/0",
                 k, iss0_valid, iss0_addr);
      end
      n_cmp++;
      if (iss1_valid !== 1'b1 || iss1_addr !== 3'(k) || entry_clr !== exp) begin
        n_err++;
        $display("FAIL bp_port1_%0d: got v1=%b a1=%0d clr=%b want 1/%0d/%b",
                 k, iss1_valid, iss1_addr, entry_clr, k, exp);
      end
      m = m & ~exp;
      set_mask(m);
      tick();
    end
    n_cmp++;
    if (iss0_addr !== 3'd0 || iss1_addr !== 3'd5 || dut.rr_ptr !== 3'd6) begin
      n_err++;
      $display("FAIL bp_end: got a0=%0d a1=%0d ptr=%0d want 0/5/6",
               iss0_addr, iss1_addr, dut.rr_ptr);
    end
    iss1_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    set_mask(8'b0000_0011);
    tick();
    n_cmp++;
    if (iss0_addr !== 3'd0 || iss1_addr !== 3'd1 || dut.rr_ptr !== 3'd2) begin
      n_err++;
      $display("FAIL flush_setup: got a0=%0d a1=%0d ptr=%0d want 0/1/2",
               iss0_addr, iss1_addr, dut.rr_ptr);
    end
    flush      = 1'b1;
    iss0_ready = 1'b1;
    #1;
    n_cmp++;
    if (entry_clr !== 8'h00) begin
      n_err++; $display("FAIL flush_clr: got %b want 0", entry_clr);
    end
    tick();
    n_cmp++;
    if (iss0_valid !== 1'b0 || iss1_valid !== 1'b0 || dut.rr_ptr !== 3'd2) begin
      n_err++;
      $display("FAIL flush_idle: got v0=%b v1=%b ptr=%0d want 0/0/2",
               iss0_valid, iss1_valid, dut.rr_ptr);
    end
    flush      = 1'b0;
    iss0_ready = 1'b0;
    tick();
    n_cmp++;
    if (iss0_addr !== 3'd0 || iss1_addr !== 3'd1 || iss1_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_regrant: got a0=%0d a1=%0d v1=%b want 0/1/1",
               iss0_addr, iss1_addr, iss1_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_mask(8'b0000_0011);
    tick();
    iss1_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (iss1_valid !== 1'b0 || iss0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_valid: got v0=%b v1=%b want 0/0",
               iss0_valid, iss1_valid);
    end
    n_cmp++;
    if (dut.rr_ptr !== 3'd0 || entry_clr !== 8'h00) begin
      n_err++;
      $display("FAIL async_state: got ptr=%0d clr=%b want 0/0",
               dut.rr_ptr, entry_clr);
    end
    iss1_ready = 1'b0;
    #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_wrap();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
